alarm_sounder: RTL and testbench

Drives the piezo buzzer from the alarm-compare stage's `ALARM_DOING` level. It sits directly downstream of the time-compare block. A rising edge on `ALARM_DOING` starts a ring session: a square-wave tone gated by a beep/gap cadence. The session ends when the user stops it or the ring timeout expires, and the user may snooze it a limited number of times. All timing is in CLK cycles; the system clock is 100 kHz.

---
 rtl/alarm_sounder_if.sv | 31 +++
 rtl/alarm_sounder.sv | 193 +++++++++++++++++++
 tb/tb_alarm_sounder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_sounder_if.sv
// alarm_sounder_if: signal bundle between the alarm logic and the sounder.
// master drives ALARM_DOING/STOP_KEY/SNOOZE_KEY; slave drives the buzzer and status.
interface alarm_sounder_if;
    logic       ALARM_DOING;
    logic       STOP_KEY;
    logic       SNOOZE_KEY;
    logic       PIEZO;
    logic       RINGING;
    logic       SNOOZING;
    logic [1:0] SNOOZE_CNT;

    modport master (
        output ALARM_DOING,
        output STOP_KEY,
        output SNOOZE_KEY,
        input  PIEZO,
        input  RINGING,
        input  SNOOZING,
        input  SNOOZE_CNT
    );

    modport slave (
        input  ALARM_DOING,
        input  STOP_KEY,
        input  SNOOZE_KEY,
        output PIEZO,
        output RINGING,
        output SNOOZING,
        output SNOOZE_CNT
    );
endinterface

// File: rtl/alarm_sounder.sv
// alarm_sounder: rings a gated square-wave tone on each ALARM_DOING rise.
// Ports: CLK, RESETN (sync, active-low), bus (alarm_sounder_if.slave).
// Macro ALARM_SNOOZE_EN builds the SNOOZE state, snooze timer and counter.
module alarm_sounder #(
    parameter int HALF_CYC   = 25,
    parameter int ON_CYC     = 20000,
    parameter int OFF_CYC    = 20000,
    parameter int RING_CYC   = 3000000,
    parameter int SNOOZE_CYC = 30000000,
    parameter int MAX_SNOOZE = 3
) (
    input  logic           CLK,
    input  logic           RESETN,
    alarm_sounder_if.slave bus
);

    localparam int CAD_CYC = ON_CYC + OFF_CYC;
    localparam int TONE_W  = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int CAD_W   = (CAD_CYC > 1) ? $clog2(CAD_CYC) : 1;
    localparam int RING_W  = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(HALF_CYC - 1);
    localparam logic [CAD_W-1:0]  CAD_LAST  = CAD_W'(CAD_CYC - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_CYC - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = (SNOOZE_CYC > 1) ? $clog2(SNOOZE_CYC) : 1;
    localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_CYC - 1);
    localparam logic [1:0]       MAX_CNT  = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;
`else
    localparam int unused_snooze_params = SNOOZE_CYC + MAX_SNOOZE;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RING = 1'b1
    } state_t;
`endif

    state_t state, state_n;

    logic              doing_d;
    logic              rise;
    logic [RING_W-1:0] ring_t, ring_t_n;
    logic [CAD_W-1:0]  cad, cad_n, cad_step;
    logic [TONE_W-1:0] tone, tone_n;
    logic              piezo, piezo_n;
    logic              restart;
    logic              enter_ring;
    logic              stay_ring;
    logic              beep_on;
    logic              beep_next;
    logic              toggle;

`ifdef ALARM_SNOOZE_EN
    logic [SNZ_W-1:0] snz_t, snz_t_n;
    logic [1:0]       cnt, cnt_n;
    logic             snooze_ok;
`else
    logic             unused_snooze_key;
    assign unused_snooze_key = bus.SNOOZE_KEY;
`endif

    assign rise = bus.ALARM_DOING & ~doing_d;

    // Cadence position now and after this edge decide the tone gating.
    assign beep_on   = 32'(cad) < 32'(ON_CYC);
    assign cad_step  = (cad == CAD_LAST) ? '0 : cad + CAD_W'(1);
    assign beep_next = 32'(cad_step) < 32'(ON_CYC);
    assign toggle    = beep_on && (tone == TONE_LAST);

`ifdef ALARM_SNOOZE_EN
    assign snooze_ok = bus.SNOOZE_KEY && (cnt < MAX_CNT);
`endif

    always_comb begin
        state_n = state;
        restart = 1'b0;
`ifdef ALARM_SNOOZE_EN
        cnt_n   = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = RING;
`ifdef ALARM_SNOOZE_EN
                    cnt_n   = '0;
`endif
                end
            end
            RING: begin
                if (bus.STOP_KEY) begin
                    state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_ok) begin
                    state_n = SNOOZE;
                    cnt_n   = cnt + 2'd1;
`endif
                end else if (rise) begin
                    restart = 1'b1;
                end else if (ring_t == RING_LAST) begin
                    state_n = IDLE;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (bus.STOP_KEY) begin
                    state_n = IDLE;
                end else if (rise) begin
                    state_n = RING;
                end else if (snz_t == SNZ_LAST) begin
                    state_n = RING;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Any entry into RING (fresh, resumed or restarted) starts from zero.
    assign enter_ring = (state_n == RING) && ((state != RING) || restart);
    assign stay_ring  = (state_n == RING) && !enter_ring;

    always_comb begin
        ring_t_n = '0;
        cad_n    = '0;
        tone_n   = '0;
        piezo_n  = 1'b0;
        if (stay_ring) begin
            ring_t_n = ring_t + RING_W'(1);
            cad_n    = cad_step;
            if (beep_on && beep_next) begin
                tone_n = (tone == TONE_LAST) ? '0 : tone + TONE_W'(1);
            end
            // Force silence as soon as the next cycle falls in the gap.
            if (beep_next) begin
                piezo_n = piezo ^ toggle;
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_comb begin
        snz_t_n = '0;
        if ((state == SNOOZE) && (state_n == SNOOZE)) begin
            snz_t_n = snz_t + SNZ_W'(1);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= IDLE;
            doing_d <= 1'b0;
            ring_t  <= '0;
            cad     <= '0;
            tone    <= '0;
            piezo   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_t   <= '0;
            cnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            doing_d <= bus.ALARM_DOING;
            ring_t  <= ring_t_n;
            cad     <= cad_n;
            tone    <= tone_n;
            piezo   <= piezo_n;
`ifdef ALARM_SNOOZE_EN
            snz_t   <= snz_t_n;
            cnt     <= cnt_n;
`endif
        end
    end

    assign bus.PIEZO   = piezo;
    assign bus.RINGING = (state == RING);

`ifdef ALARM_SNOOZE_EN
    assign bus.SNOOZING   = (state == SNOOZE);
    assign bus.SNOOZE_CNT = cnt;
`else
    assign bus.SNOOZING   = 1'b0;
    assign bus.SNOOZE_CNT = 2'd0;
`endif

endmodule

// File: tb/tb_alarm_sounder.sv
// tb_alarm_sounder: vector table plus scoreboarded sequences for alarm_sounder.
// Works with and without ALARM_SNOOZE_EN defined.
module tb_alarm_sounder;

    localparam int HALF = 2;
    localparam int ON   = 8;
    localparam int OFF  = 8;
    localparam int RING = 100;
    localparam int SNZ  = 50;
    localparam int MAXS = 2;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic       ring;
        logic       snz;
        logic [1:0] cnt;
        logic       piezo;
    } exp_t;

    typedef struct packed {
        logic rstn;
        logic alarm;
        logic stop;
        logic snooze;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;

    alarm_sounder_if bus ();

    alarm_sounder #(
        .HALF_CYC  (HALF),
        .ON_CYC    (ON),
        .OFF_CYC   (OFF),
        .RING_CYC  (RING),
        .SNOOZE_CYC(SNZ),
        .MAX_SNOOZE(MAXS)
    ) dut (
        .CLK   (clk),
        .RESETN(rstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t got_e;
    int   ring_run = 0;
    int   last_ring_len = 0;

    // Reference model: one timer per state, piezo derived from ring time.
    int m_st = 0;
    int m_t = 0;
    int m_cnt = 0;
    bit m_dd = 1'b0;

    task automatic check1(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, req);
        end
    endtask

    function automatic logic exp_piezo(input int t);
        int c;
        c = t % (ON + OFF);
        return (c < ON) && (((c / HALF) % 2) == 1);
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.ring  = (m_st == 1);
        e.snz   = (m_st == 2);
        e.cnt   = 2'(m_cnt);
        e.piezo = (m_st == 1) ? exp_piezo(m_t) : 1'b0;
        return e;
    endfunction

    task automatic model_step(input bit r, input bit a, input bit s, input bit z);
        bit rs;
        if (!r) begin
            m_st = 0; m_t = 0; m_cnt = 0; m_dd = 1'b0;
            return;
        end
        rs = a && !m_dd;
        m_dd = a;
        case (m_st)
            0: if (rs) begin m_st = 1; m_t = 0; m_cnt = 0; end
            1: begin
                if (s) begin
                    m_st = 0; m_t = 0;
                end else if (z && SNZ_EN && m_cnt < MAXS) begin
                    m_st = 2; m_t = 0; m_cnt++;
                end else if (rs) begin
                    m_t = 0;
                end else if (m_t == RING - 1) begin
                    m_st = 0; m_t = 0;
                end else begin
                    m_t++;
                end
            end
            default: begin
                if (s) begin
                    m_st = 0; m_t = 0;
                end else if (rs || m_t == SNZ - 1) begin
                    m_st = 1; m_t = 0;
                end else begin
                    m_t++;
                end
            end
        endcase
    endtask

    task automatic drive(input bit r, input bit a, input bit s, input bit z);
        @(negedge clk);
        rstn = r;
        bus.ALARM_DOING = a;
        bus.STOP_KEY = s;
        bus.SNOOZE_KEY = z;
        model_step(r, a, s, z);
    endtask

    task automatic run(input bit r, input bit a, input bit s, input bit z,
                       input int n);
        for (int i = 0; i < n; i++) begin
            drive(r, a, s, z);
            sb.push_back(model_exp());
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.RINGING === 1'b1) begin
            ring_run++;
        end else if (ring_run != 0) begin
            last_ring_len = ring_run;
            ring_run = 0;
        end
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check1("ringing", int'(bus.RINGING), int'(got_e.ring));
            check1("snoozing", int'(bus.SNOOZING), int'(got_e.snz));
            check1("snooze_cnt", int'(bus.SNOOZE_CNT), int'(got_e.cnt));
            check1("piezo", int'(bus.PIEZO), int'(got_e.piezo));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vec [13];

    initial begin
        vec[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b0}};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b0}};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b1}};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b1}};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b0}};
        vec[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b0}};
        vec[10] = '{1'b1, 1'b1, 1'b1, 1'b1, '{1'b0, 1'b0, 2'd0, 1'b0}};
        vec[11] = '{1'b1, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};
        vec[12] = '{1'b1, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};

        rstn = 1'b0;
        bus.ALARM_DOING = 1'b0;
        bus.STOP_KEY = 1'b0;
        bus.SNOOZE_KEY = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].rstn, vec[i].alarm, vec[i].stop, vec[i].snooze);
            sb.push_back(vec[i].e);
        end

        // Basic ring: held alarm, full timeout
        run(1, 1, 0, 0, 40);
        run(1, 0, 0, 0, 80);
        @(negedge clk);
        check1("ring_len", last_ring_len, RING);

        // Stop ten cycles in, alarm still high: no re-ring
        run(1, 1, 0, 0, 10);
        run(1, 1, 1, 0, 1);
        run(1, 1, 0, 0, 10);
        run(1, 0, 0, 0, 2);

`ifdef ALARM_SNOOZE_EN
        // Two snoozes, third ignored, then rise restarts the ring
        run(1, 1, 0, 0, 5);
        run(1, 1, 0, 1, 1);
        run(1, 1, 0, 0, 55);
        run(1, 0, 0, 1, 1);
        run(1, 0, 0, 0, 55);
        run(1, 0, 0, 1, 1);
        run(1, 0, 0, 0, 10);
        run(1, 1, 0, 0, 1);
        run(1, 1, 0, 0, 105);

        // Fresh alarm clears count; rise during snooze; stop beats snooze
        run(1, 0, 0, 0, 2);
        run(1, 1, 0, 0, 3);
        run(1, 1, 0, 1, 1);
        run(1, 0, 0, 0, 10);
        run(1, 1, 0, 0, 1);
        run(1, 1, 0, 0, 4);
        run(1, 1, 1, 1, 1);
        run(1, 0, 0, 0, 3);
`else
        // Snooze key has no effect; ring ends on timeout
        run(1, 1, 0, 0, 5);
        run(1, 1, 0, 1, 1);
        run(1, 1, 0, 0, 5);
        run(1, 1, 0, 1, 1);
        run(1, 0, 0, 0, 100);
`endif

        // One-cycle reset mid-ring, alarm still high counts as a rise
        run(1, 0, 0, 0, 2);
        run(1, 1, 0, 0, 10);
        run(0, 1, 0, 0, 1);
        run(1, 1, 0, 0, 5);
        run(1, 1, 1, 0, 1);
        run(1, 0, 0, 0, 2);

        repeat (3) @(posedge clk);
        #2;
        check1("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
